// File: rtl/prbs_pkg.sv
// Shared PRBS7 definitions for the generator/checker pair.
// Polynomial x^7 + x^6 + 1: s(n) = s(n-6) ^ s(n-7).
// No ports; imported by prbs7_checker.
package prbs_pkg;

  localparam int unsigned PRBS7_TAP_HI = 6;
  localparam int unsigned PRBS7_TAP_LO = 5;
  localparam int unsigned PRBS7_LEN    = 7;

  // Generator reset seed.
  localparam logic [PRBS7_LEN-1:0] PRBS7_SEED = 7'h7f;

  typedef enum logic {
    HUNT,
    LOCKED
  } state_e;

  // Expected next bit from a 7-bit history, newest bit at [0].
  function automatic logic prbs7_exp(input logic [PRBS7_LEN-1:0] hist);
    return hist[PRBS7_TAP_HI] ^ hist[PRBS7_TAP_LO];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear has priority).
// Ports:
//   clk_i  - clock
//   rst_ni - asynchronous active-low reset
//   clr_i  - synchronous clear to zero
//   inc_i  - increment by one, holding at all-ones
//   cnt_o  - current count
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/prbs7_checker.sv
// PRBS7 receive checker: self-synchronises to an x^7+x^6+1 stream, declares
// lock after LOCK_CNT consecutive matches, then counts checked bits and
// errors. Drops back to hunting when LOSS_THRESH errors fall inside one
// LOSS_WIN-bit window.
// Ports:
//   clk_i       - clock
//   rst_ni      - asynchronous active-low reset
//   bit_i       - received serial bit
//   bit_valid_i - bit_i is consumed only when high; otherwise all state holds
//   clear_i     - synchronous clear of err_cnt_o / bit_cnt_o
//   locked_o    - checker locked to the sequence
//   err_o       - one-cycle pulse per errored bit while locked
//   err_cnt_o   - saturating error count (locked only)
//   bit_cnt_o   - saturating checked-bit count (locked only)
module prbs7_checker
  import prbs_pkg::*;
#(
  parameter int unsigned LOCK_CNT    = 16,
  parameter int unsigned LOSS_WIN    = 64,
  parameter int unsigned LOSS_THRESH = 8,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             bit_i,
  input  logic             bit_valid_i,
  input  logic             clear_i,
  output logic             locked_o,
  output logic             err_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [CNT_W-1:0] bit_cnt_o
);

  localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned WIN_W   = $clog2(LOSS_WIN + 1);
  localparam int unsigned THR_W   = $clog2(LOSS_THRESH + 1);

  state_e                 state_q, state_d;
  logic [PRBS7_LEN-1:0]   rx_q, rx_d;
  logic [2:0]             fill_q, fill_d;
  logic [MATCH_W-1:0]     match_q, match_d;
  logic [WIN_W-1:0]       win_q, win_d;
  logic [THR_W-1:0]       werr_q, werr_d;
  logic                   err_q, err_d;

  logic                   exp_bit;
  logic                   mismatch;
  logic                   zero_guard;
  logic [THR_W-1:0]       werr_next;
  logic                   inc_bit;
  logic                   inc_err;

  assign exp_bit    = prbs7_exp(rx_q);
  assign mismatch   = (bit_i != exp_bit);
  // All-zero history predicting a zero would lock onto a dead line.
  assign zero_guard = (rx_q == '0) && !bit_i;
  // werr_q < LOSS_THRESH while locked, so this sum never overflows THR_W.
  assign werr_next  = werr_q + THR_W'(mismatch);

  always_comb begin
    state_d = state_q;
    rx_d    = rx_q;
    fill_d  = fill_q;
    match_d = match_q;
    win_d   = win_q;
    werr_d  = werr_q;
    err_d   = 1'b0;
    inc_bit = 1'b0;
    inc_err = 1'b0;

    if (bit_valid_i) begin
      case (state_q)
        HUNT: begin
          rx_d = {rx_q[PRBS7_LEN-2:0], bit_i};
          if (fill_q != 3'd7) begin
            fill_d = fill_q + 3'd1;
          end else if (mismatch || zero_guard) begin
            match_d = '0;
          end else if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
            state_d = LOCKED;
            match_d = '0;
            win_d   = '0;
            werr_d  = '0;
          end else begin
            match_d = match_q + 1'b1;
          end
        end

        LOCKED: begin
          // Flywheel: history follows the prediction so one flipped bit
          // produces exactly one error instead of three.
          rx_d    = {rx_q[PRBS7_LEN-2:0], exp_bit};
          inc_bit = 1'b1;
          if (mismatch) begin
            err_d   = 1'b1;
            inc_err = 1'b1;
          end
          if (werr_next == THR_W'(LOSS_THRESH)) begin
            state_d = HUNT;
            fill_d  = '0;
            match_d = '0;
            win_d   = '0;
            werr_d  = '0;
          end else if (win_q == WIN_W'(LOSS_WIN - 1)) begin
            win_d  = '0;
            werr_d = '0;
          end else begin
            win_d  = win_q + 1'b1;
            werr_d = werr_next;
          end
        end

        default: begin
          state_d = HUNT;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= HUNT;
      rx_q    <= '0;
      fill_q  <= '0;
      match_q <= '0;
      win_q   <= '0;
      werr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rx_q    <= rx_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      win_q   <= win_d;
      werr_q  <= werr_d;
      err_q   <= err_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (clear_i),
    .inc_i  (inc_err),
    .cnt_o  (err_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_bit_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (clear_i),
    .inc_i  (inc_bit),
    .cnt_o  (bit_cnt_o)
  );

  assign locked_o = (state_q == LOCKED);
  assign err_o    = err_q;

endmodule

// File: tb/tb_prbs7_checker.sv
module tb_prbs7_checker;

  localparam int unsigned LOCK_CNT    = 16;
  localparam int unsigned LOSS_WIN    = 64;
  localparam int unsigned LOSS_THRESH = 8;
  localparam int unsigned CNT_W       = 10;
  localparam int          SAT         = (1 << CNT_W) - 1;

  logic             clk_i       = 1'b0;
  logic             rst_ni      = 1'b0;
  logic             bit_i       = 1'b0;
  logic             bit_valid_i = 1'b0;
  logic             clear_i     = 1'b0;
  logic             locked_o;
  logic             err_o;
  logic [CNT_W-1:0] err_cnt_o;
  logic [CNT_W-1:0] bit_cnt_o;

  always #5 clk_i = ~clk_i;

  prbs7_checker #(
    .LOCK_CNT    (LOCK_CNT),
    .LOSS_WIN    (LOSS_WIN),
    .LOSS_THRESH (LOSS_THRESH),
    .CNT_W       (CNT_W)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .bit_i       (bit_i),
    .bit_valid_i (bit_valid_i),
    .clear_i     (clear_i),
    .locked_o    (locked_o),
    .err_o       (err_o),
    .err_cnt_o   (err_cnt_o),
    .bit_cnt_o   (bit_cnt_o)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Keeps the last seven stream bits as a queue (oldest first) and applies
  // the hunt/lock rules per consumed bit.
  bit m_hist[$];
  bit m_locked = 0;
  bit m_pulse  = 0;
  int m_fill = 0, m_run = 0, m_wpos = 0, m_werr = 0, m_errc = 0, m_bitc = 0;
  bit m_e, m_b, m_ok;
  int m_ones;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_hist   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      m_locked = 0; m_pulse = 0;
      m_fill = 0; m_run = 0; m_wpos = 0; m_werr = 0; m_errc = 0; m_bitc = 0;
    end else begin
      m_pulse = 0;
      if (bit_valid_i) begin
        m_b = bit_i;
        m_e = m_hist[0] ^ m_hist[1];   // s(n-7) ^ s(n-6)
        m_ones = 0;
        foreach (m_hist[k]) m_ones += int'(m_hist[k]);
        if (!m_locked) begin
          if (m_fill < 7) begin
            m_fill++;
          end else begin
            m_ok = (m_b == m_e) && !(m_ones == 0 && m_b == 0);
            m_run = m_ok ? m_run + 1 : 0;
            if (m_run == LOCK_CNT) begin
              m_locked = 1; m_run = 0; m_wpos = 0; m_werr = 0;
            end
          end
          m_hist.push_back(m_b);
        end else begin
          if (m_bitc < SAT) m_bitc++;
          if (m_b != m_e) begin
            m_pulse = 1;
            if (m_errc < SAT) m_errc++;
            m_werr++;
          end
          m_hist.push_back(m_e);
          if (m_werr == LOSS_THRESH) begin
            m_locked = 0; m_fill = 0; m_run = 0; m_wpos = 0; m_werr = 0;
          end else begin
            m_wpos++;
            if (m_wpos == LOSS_WIN) begin
              m_wpos = 0; m_werr = 0;
            end
          end
        end
        void'(m_hist.pop_front());
      end
      if (clear_i) begin
        m_errc = 0; m_bitc = 0;
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  int pulse_cnt = 0;
  always @(negedge clk_i) begin
    if (rst_ni) begin
      check("locked", locked_o,  int'(m_locked));
      check("err",    err_o,     int'(m_pulse));
      check("errcnt", err_cnt_o, m_errc);
      check("bitcnt", bit_cnt_o, m_bitc);
      if (err_o) pulse_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  logic [6:0] g = 7'h7f;

  task automatic gen(output logic b);
    b = g[6] ^ g[5];
    g = {g[5:0], b};
  endtask

  task automatic drive(input logic b, input logic v, input logic c);
    bit_i = b; bit_valid_i = v; clear_i = c;
    @(posedge clk_i); #1;
  endtask

  task automatic clean(input int n);
    logic b;
    for (int i = 0; i < n; i++) begin
      gen(b);
      drive(b, 1'b1, 1'b0);
    end
  endtask

  task automatic do_reset();
    bit_valid_i = 0; clear_i = 0;
    rst_ni = 0;
    #2;
    check("rst_locked", locked_o, 0);
    check("rst_err",    err_o, 0);
    check("rst_errcnt", err_cnt_o, 0);
    check("rst_bitcnt", bit_cnt_o, 0);
    @(posedge clk_i); #1;
    rst_ni = 1;
  endtask

  initial begin
    logic b;
    int p0, seen;

    repeat (3) @(posedge clk_i);
    #1;
    check("por_locked", locked_o, 0);
    check("por_errcnt", err_cnt_o, 0);
    check("por_bitcnt", bit_cnt_o, 0);
    rst_ni = 1;

    // Clean lock: 23rd valid bit, 977 checked bits after 1000.
    clean(22);
    check("lock_22", locked_o, 0);
    clean(1);
    check("lock_23", locked_o, 1);
    clean(977);
    check("bits_1000", bit_cnt_o, 977);
    check("errs_1000", err_cnt_o, 0);

    // Single flipped bit: one pulse, one error, lock kept; bit count saturates.
    p0 = pulse_cnt;
    clean(199);
    gen(b); drive(~b, 1'b1, 1'b0);
    clean(20);
    check("single_err", err_cnt_o, 1);
    check("single_pulse", pulse_cnt - p0, 1);
    check("single_lock", locked_o, 1);
    check("bit_sat", bit_cnt_o, SAT);

    // Clear, then 8 errors inside one window forces loss of lock.
    gen(b); drive(b, 1'b1, 1'b1);
    check("clr_err", err_cnt_o, 0);
    check("clr_bit", bit_cnt_o, 0);
    for (int i = 0; i < 70 && m_wpos != 0; i++) clean(1);
    check("win_align", m_wpos, 0);
    clean(2);
    for (int i = 0; i < 7; i++) begin gen(b); drive(~b, 1'b1, 1'b0); end
    check("loss_7", locked_o, 1);
    gen(b); drive(~b, 1'b1, 1'b0);
    check("loss_8", locked_o, 0);
    check("loss_errcnt", err_cnt_o, 8);
    clean(22);
    check("relock_22", locked_o, 0);
    clean(1);
    check("relock_23", locked_o, 1);

    // Error coinciding with clear, then mid-stream reset.
    clean(10);
    gen(b); drive(~b, 1'b1, 1'b1);
    check("clrerr_pulse", err_o, 1);
    check("clrerr_cnt", err_cnt_o, 0);
    check("clrerr_bits", bit_cnt_o, 0);
    clean(5);
    do_reset();
    clean(22);
    check("rst_relock_22", locked_o, 0);
    clean(1);
    check("rst_relock_23", locked_o, 1);

    // Constant streams never lock.
    for (int c = 0; c < 2; c++) begin
      do_reset();
      seen = 0;
      for (int i = 0; i < 500; i++) begin
        drive(c[0], 1'b1, 1'b0);
        if (locked_o) seen++;
      end
      check(c == 0 ? "zeros_nolock" : "ones_nolock", seen, 0);
      check(c == 0 ? "zeros_errcnt" : "ones_errcnt", err_cnt_o, 0);
    end

    // Alternating valid: lock point counted in valid bits.
    do_reset();
    for (int i = 1; i <= 30; i++) begin
      gen(b); drive(b, 1'b1, 1'b0);
      drive(1'($urandom), 1'b0, 1'b0);
      if (i == 22) check("toggle_22", locked_o, 0);
      if (i == 23) check("toggle_23", locked_o, 1);
    end

    // Randomised run against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      int ph, rate;
      logic v, c, flip;
      ph   = (i / 500) % 3;
      rate = (ph == 0) ? 100 : (ph == 1) ? 5 : 0;
      v    = ($urandom_range(3) != 0);
      c    = ($urandom_range(199) == 0);
      flip = (rate != 0) && ($urandom_range(rate - 1) == 0);
      if (v) begin
        gen(b);
        drive(b ^ flip, 1'b1, c);
      end else begin
        drive(1'($urandom), 1'b0, c);
      end
    end

    repeat (2) @(posedge clk_i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prbs7_checker.md
Name: prbs7_checker

Overview:
- Receive-side companion to the PRBS7 generator (x^7 + x^6 + 1). Sits directly downstream and consumes its serial bit stream, either directly or after a loopback/DUT path.
- Self-synchronises to the incoming sequence, declares lock, then counts bit errors and checked bits.
- Drops lock when errors become dense, and resumes hunting.
- Used for link BIST and for loopback characterisation.

Parameters:
- LOCK_CNT, 16: consecutive matching bits required in HUNT before declaring lock.
- LOSS_WIN, 64: length of the error-density window in LOCKED, in valid bits.
- LOSS_THRESH, 8: errors within one window that force a return to HUNT.
- CNT_W, 16: width of the error and bit counters.

Ports:
- clk_i, input, 1: single clock.
- rst_ni, input, 1: reset, asynchronous, active-low.
- bit_i, input, 1: received serial bit (generator prbs_o).
- bit_valid_i, input, 1: bit_i is sampled only when this is 1. Tie to the inverse of the generator freeze.
- clear_i, input, 1: synchronous clear of err_cnt_o and bit_cnt_o.
- locked_o, output, 1: checker is locked to the sequence.
- err_o, output, 1: one-cycle pulse on each errored bit while locked.
- err_cnt_o, output, CNT_W: saturating count of errors while locked.
- bit_cnt_o, output, CNT_W: saturating count of bits checked while locked.

Behaviour:
- Reset is asynchronous, active-low. It clears everything:
  - state to HUNT, history register rx_q to 0, all counters to 0.
  - locked_o = 0, err_o = 0, err_cnt_o = 0, bit_cnt_o = 0.
  - Reset mid-operation discards all progress; the checker restarts with a fresh fill.
- History: rx_q is 7 bits, newest bit at [0]. Expected bit exp = rx_q[6] ^ rx_q[5]. This matches generator output recurrence s(n) = s(n-6) ^ s(n-7).
- All state changes occur only on edges where bit_valid_i = 1. When bit_valid_i = 0, everything holds and err_o = 0.
- HUNT state:
  - A fill counter counts 0..7. The first 7 valid bits are shifted into rx_q without comparison.
  - After fill, each valid bit is compared with exp:
    - Match: the match counter increments.
    - Mismatch: the match counter resets to 0.
  - The received bit is always shifted in (self-sync).
  - Zero-lock guard: if rx_q == 0 and bit_i == 0, treat as a mismatch. An all-zero stream never locks.
  - When the match counter reaches LOCK_CNT, go to LOCKED. Transition check: clean stream, LOCK_CNT = 16 gives lock on the 23rd valid bit.
- LOCKED state:
  - Each valid bit increments bit_cnt.
  - On mismatch: err_o pulses, err_cnt increments, and the window error counter increments.
  - rx_q is fed with exp, not bit_i (flywheel). A single flipped bit therefore counts exactly one error.
  - Window counter: runs 0..LOSS_WIN-1 and wraps. At wrap, the window error counter resets to 0.
  - If the window error count reaches LOSS_THRESH, go to HUNT on that same edge. The fill counter and match counter reset, and locked_o falls.
  - err_cnt_o and bit_cnt_o hold their values across loss of lock.
- Outputs are registered. locked_o, err_o and the counters update on the same edge that samples the bit and are visible the following cycle.
- Counters saturate at 2^CNT_W - 1 and never wrap.
- clear_i:
  - Zeroes err_cnt and bit_cnt. It does not affect state, rx_q, or the window counters.
  - When clear_i coincides with a counted bit, clear wins: the counters become 0. err_o still pulses if that bit is in error.
- A mismatch on the same edge as the HUNT-to-LOCKED transition is impossible by construction: the transition requires a match.

Decomposition:
- Shared package prbs_pkg holds:
  - PRBS7_TAP_HI = 6, PRBS7_TAP_LO = 5, PRBS7_LEN = 7.
  - The state enum {HUNT, LOCKED}.
  - The generator's reset seed 7'h7f.
- One natural sub-module: sat_counter (parameterised width; inc and clr inputs; clear has priority). It is instantiated twice, for err_cnt and bit_cnt.

Test Plan:
- Generator reset with seed 7f, freeze = 0, output looped directly to bit_i → locked_o rises after the 23rd valid bit; err_cnt_o = 0; bit_cnt_o = 977 after 1000 valid bits.
- Locked; flip exactly one bit at bit index 200 → single err_o pulse; err_cnt_o = 1; locked_o stays 1.
- Locked; inject 8 errors within one 64-bit window → locked_o falls on the 8th error; err_cnt_o = 8; clean stream afterwards re-locks after 7 + 16 bits.
- Constant bit_i = 0 for 500 bits → locked_o never asserts; err_cnt_o = 0. Constant bit_i = 1 also never locks (1^1 = 0 mismatch).
- bit_valid_i toggling 1/0 every cycle with a clean stream → same lock point counted in valid bits; all state holds on invalid cycles.
- Error injected on the same cycle as clear_i, then rst_ni asserted mid-stream → err_o pulses and err_cnt_o = 0; after reset all outputs are 0 and lock re-acquires after 23 valid bits.
